// File: rtl/prim_fifo_sync_wm_pkg.sv
// Shared pointer helpers for the prim FIFO family: wrap-aware increment and
// pointer-difference occupancy on pointers of up to PtrMaxW bits.
package prim_fifo_sync_wm_pkg;

   localparam int unsigned PtrMaxW = 32;

   typedef logic [PtrMaxW-1:0] ptr_word_t;

   typedef struct packed {
      logic full;
      logic empty;
   } fifo_flags_t;

   // Value bits needed for a pointer that indexes 0..depth-1 (at least one).
   function automatic int unsigned ptrv_width(input int unsigned depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

   // Pointer layout: bit vw is the wrap bit, bits vw-1:0 hold the value.
   function automatic ptr_word_t ptr_incr(input ptr_word_t   ptr,
                                          input int unsigned vw,
                                          input int unsigned depth);
      ptr_word_t wrap_bit;
      ptr_word_t val;
      wrap_bit = ptr_word_t'(1) << vw;
      val      = ptr & (wrap_bit - 1);
      if (val == ptr_word_t'(depth - 1)) return (ptr & wrap_bit) ^ wrap_bit;
      return (ptr & wrap_bit) | (val + 1);
   endfunction

   function automatic ptr_word_t ptr2occ(input ptr_word_t   wptr,
                                         input ptr_word_t   rptr,
                                         input int unsigned vw,
                                         input int unsigned depth);
      ptr_word_t wrap_bit;
      ptr_word_t wv;
      ptr_word_t rv;
      wrap_bit = ptr_word_t'(1) << vw;
      wv       = wptr & (wrap_bit - 1);
      rv       = rptr & (wrap_bit - 1);
      if ((wptr & wrap_bit) == (rptr & wrap_bit)) return wv - rv;
      return ptr_word_t'(depth) - rv + wv;
   endfunction

endpackage

// File: rtl/prim_fifo_sync_wm_if.sv
// Valid/ready write and read channels of the synchronous FIFO.
interface prim_fifo_sync_wm_if #(
   parameter int unsigned Width = 16
);
   logic             wvalid;
   logic             wready;
   logic [Width-1:0] wdata;
   logic             rvalid;
   logic             rready;
   logic [Width-1:0] rdata;

   modport master (
      output wvalid, wdata, rready,
      input  wready, rvalid, rdata
   );

   modport slave (
      input  wvalid, wdata, rready,
      output wready, rvalid, rdata
   );
endinterface

// File: rtl/prim_fifo_sync_wm.sv
// Single-clock FIFO: arbitrary depth, optional fall-through, synchronous flush,
// almost-full/almost-empty watermarks and a sticky occupancy integrity error.
module prim_fifo_sync_wm
   import prim_fifo_sync_wm_pkg::*;
#(
   parameter int unsigned Width             = 16,
   parameter int unsigned Depth             = 4,
   parameter bit          Pass              = 1'b0,
   parameter bit          OutputZeroIfEmpty = 1'b0,
   localparam int unsigned DepthW           = $clog2(Depth + 1)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              clr,
   prim_fifo_sync_wm_if.slave bus,
   input  logic [DepthW-1:0] afull_thresh,
   input  logic [DepthW-1:0] aempty_thresh,
   output logic [DepthW-1:0] depth,
   output logic              afull,
   output logic              aempty,
   output logic              err
);

   localparam int unsigned PTRV_W = ptrv_width(Depth);
   localparam int unsigned PtrW   = PTRV_W + 1;

   logic [PtrW-1:0]   wptr, rptr;
   logic [PtrW-1:0]   wptr_nxt, rptr_nxt;
   logic [DepthW-1:0] depth_q;
   logic [DepthW-1:0] occ;
   logic              err_q;
   logic              err_set;
   fifo_flags_t       flags;
   logic              fall_through;
   logic              push, pop;
   logic [Width-1:0]  rdata_raw;
   logic [Width-1:0]  storage [Depth];

   always_comb begin
      flags.empty = (wptr == rptr);
      flags.full  = (wptr[PTRV_W-1:0] == rptr[PTRV_W-1:0]) && (wptr[PTRV_W] != rptr[PTRV_W]);
   end

   // Handshakes are gated by reset and flush so nothing is accepted in those cycles.
   assign bus.wready   = rst_n && !clr && !flags.full;
   assign bus.rvalid   = rst_n && !clr && (!flags.empty || (Pass && bus.wvalid));
   assign fall_through = Pass && flags.empty && bus.wvalid && bus.rready;
   assign push         = bus.wvalid && bus.wready && !fall_through;
   assign pop          = bus.rvalid && bus.rready && !fall_through;

   assign rdata_raw = (Pass && flags.empty) ? bus.wdata : storage[rptr[PTRV_W-1:0]];
   assign bus.rdata = (OutputZeroIfEmpty && !bus.rvalid) ? '0 : rdata_raw;

   assign wptr_nxt = PtrW'(ptr_incr(ptr_word_t'(wptr), PTRV_W, Depth));
   assign rptr_nxt = PtrW'(ptr_incr(ptr_word_t'(rptr), PTRV_W, Depth));
   assign occ      = DepthW'(ptr2occ(ptr_word_t'(wptr), ptr_word_t'(rptr), PTRV_W, Depth));
   assign err_set  = (depth_q != occ) || (flags.full && flags.empty);

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (!rst_n || clr) begin
         wptr    <= '0;
         rptr    <= '0;
         depth_q <= '0;
         err_q   <= 1'b0;
      end else begin
         if (push) wptr <= wptr_nxt;
         if (pop)  rptr <= rptr_nxt;
         if (push && !pop)      depth_q <= depth_q + DepthW'(1);
         else if (pop && !push) depth_q <= depth_q - DepthW'(1);
         if (err_set) err_q <= 1'b1;
      end
   end

   // NOTE: storage is not reset; pointers alone define which entries are valid.
   always_ff @(posedge clk) begin
      if (push) storage[wptr[PTRV_W-1:0]] <= bus.wdata;
   end

   assign depth  = depth_q;
   assign afull  = (depth_q >= afull_thresh);
   assign aempty = (depth_q <= aempty_thresh);
   assign err    = err_q;

   a_no_push_full: assert property (@(posedge clk) disable iff (!rst_n) push |-> !flags.full);
   a_no_pop_empty: assert property (@(posedge clk) disable iff (!rst_n) pop |-> !flags.empty);
   a_depth_max:    assert property (@(posedge clk) disable iff (!rst_n) depth_q <= DepthW'(Depth));
   a_no_err:       assert property (@(posedge clk) disable iff (!rst_n) !err_q);

endmodule

// File: tb/tb_prim_fifo_sync_wm.sv
// Directed bench for prim_fifo_sync_wm: a Depth=3 stored-only FIFO and a Depth=4
// fall-through FIFO, with per-instance scoreboards checked by read-side monitors.
module tb_prim_fifo_sync_wm;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic clr3 = 1'b0, clr4 = 1'b0;
   logic [1:0] afull_th3 = 2'd3, aempty_th3 = 2'd0, depth3;
   logic [2:0] afull_th4 = 3'd3, aempty_th4 = 3'd1, depth4;
   logic afull3, aempty3, err3, afull4, aempty4, err4;

   int total = 0;
   int bad   = 0;

   logic [15:0] q3[$];
   logic [15:0] q4[$];
   logic [15:0] e3, e4;

   prim_fifo_sync_wm_if #(.Width(16)) if3 ();
   prim_fifo_sync_wm_if #(.Width(16)) if4 ();

   prim_fifo_sync_wm #(.Width(16), .Depth(3), .Pass(1'b0), .OutputZeroIfEmpty(1'b0)) dut3 (
      .clk(clk), .rst_n(rst_n), .clr(clr3), .bus(if3),
      .afull_thresh(afull_th3), .aempty_thresh(aempty_th3),
      .depth(depth3), .afull(afull3), .aempty(aempty3), .err(err3)
   );

   prim_fifo_sync_wm #(.Width(16), .Depth(4), .Pass(1'b1), .OutputZeroIfEmpty(1'b1)) dut4 (
      .clk(clk), .rst_n(rst_n), .clr(clr4), .bus(if4),
      .afull_thresh(afull_th4), .aempty_thresh(aempty_th4),
      .depth(depth4), .afull(afull4), .aempty(aempty4), .err(err4)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic mid();
      @(negedge clk);
   endtask

   // Monitors: every read handshake must match the head of the scoreboard.
   always @(negedge clk) begin
      if (if3.rvalid && if3.rready) begin
         if (q3.size() == 0) check("d3 pop with empty scoreboard", 32'd1, 32'd0);
         else begin
            e3 = q3.pop_front();
            check("d3 rdata", 32'(if3.rdata), 32'(e3));
         end
      end
   end

   always @(negedge clk) begin
      if (if4.rvalid && if4.rready) begin
         if (q4.size() == 0) check("d4 pop with empty scoreboard", 32'd1, 32'd0);
         else begin
            e4 = q4.pop_front();
            check("d4 rdata", 32'(if4.rdata), 32'(e4));
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      logic [15:0] a_words [3];
      logic        exp_aempty [4];
      logic        exp_afull [4];
      a_words    = '{16'hA001, 16'hB002, 16'hC003};
      exp_aempty = '{1'b1, 1'b1, 1'b0, 1'b0};
      exp_afull  = '{1'b0, 1'b0, 1'b0, 1'b1};

      if3.wvalid = 1'b0; if3.wdata = '0; if3.rready = 1'b0;
      if4.wvalid = 1'b1; if4.wdata = 16'h0BAD; if4.rready = 1'b0;

      // Reset: outputs gated even with a pending write on the fall-through instance.
      repeat (2) step();
      mid();
      check("reset d4 rvalid gated", 32'(if4.rvalid), 32'd0);
      check("reset d4 wready gated", 32'(if4.wready), 32'd0);
      check("reset d3 wready gated", 32'(if3.wready), 32'd0);
      step();
      rst_n = 1'b1;
      mid();
      check("post-reset d3 wready", 32'(if3.wready), 32'd1);
      check("post-reset d3 rvalid", 32'(if3.rvalid), 32'd0);
      check("post-reset d3 depth", 32'(depth3), 32'd0);
      check("post-reset d4 rvalid pass", 32'(if4.rvalid), 32'd1);
      check("post-reset d4 depth", 32'(depth4), 32'd0);
      if4.wvalid = 1'b0;
      step();

      // Test 1: fill Depth=3, then drain in order.
      for (int i = 0; i < 3; i++) begin
         if3.wvalid = 1'b1;
         if3.wdata  = a_words[i];
         q3.push_back(a_words[i]);
         mid();
         check("t1 wready while filling", 32'(if3.wready), 32'd1);
         step();
      end
      if3.wdata = 16'hDDDD;
      mid();
      check("t1 wready at full", 32'(if3.wready), 32'd0);
      check("t1 depth at full", 32'(depth3), 32'd3);
      check("t1 afull at full", 32'(afull3), 32'd1);
      check("t1 wptr wrapped", 32'(dut3.wptr), 32'b100);
      step();
      if3.wvalid = 1'b0;
      if3.rready = 1'b1;
      repeat (3) begin
         mid();
         step();
      end
      mid();
      check("t1 rvalid after drain", 32'(if3.rvalid), 32'd0);
      check("t1 depth after drain", 32'(depth3), 32'd0);
      check("t1 aempty after drain", 32'(aempty3), 32'd1);
      if3.rready = 1'b0;
      step();

      // Test 2: interleaved push/pop across pointer wrap.
      if3.wvalid = 1'b1;
      if3.wdata  = 16'h2000;
      q3.push_back(16'h2000);
      step();
      for (int i = 1; i <= 7; i++) begin
         if3.wdata  = 16'h2000 + 16'(i);
         if3.rready = 1'b1;
         q3.push_back(16'h2000 + 16'(i));
         mid();
         check("t2 depth steady", 32'(depth3), 32'd1);
         step();
      end
      if3.wvalid = 1'b0;
      mid();
      step();
      if3.rready = 1'b0;
      mid();
      check("t2 depth empty", 32'(depth3), 32'd0);
      check("t2 err clear", 32'(err3), 32'd0);
      check("t2 wptr", 32'(dut3.wptr), 32'b110);
      check("t2 rptr", 32'(dut3.rptr), 32'b110);
      step();

      // Test 3: fall-through on the empty Pass instance.
      if4.wvalid = 1'b1;
      if4.rready = 1'b1;
      if4.wdata  = 16'h005A;
      q4.push_back(16'h005A);
      mid();
      check("t3 rvalid same cycle", 32'(if4.rvalid), 32'd1);
      step();
      if4.wvalid = 1'b0;
      if4.rready = 1'b0;
      mid();
      check("t3 depth stays 0", 32'(depth4), 32'd0);
      check("t3 rdata zero when idle", 32'(if4.rdata), 32'd0);
      step();

      // Test 5: watermark progression while filling 0..4.
      for (int i = 0; i < 4; i++) begin
         if4.wvalid = 1'b1;
         if4.wdata  = 16'h4000 + 16'(i);
         q4.push_back(16'h4000 + 16'(i));
         mid();
         check("t5 depth", 32'(depth4), 32'(i));
         check("t5 aempty", 32'(aempty4), 32'(exp_aempty[i]));
         check("t5 afull", 32'(afull4), 32'(exp_afull[i]));
         step();
      end
      if4.wvalid = 1'b0;
      mid();
      check("t5 depth full", 32'(depth4), 32'd4);
      check("t5 afull full", 32'(afull4), 32'd1);
      check("t5 aempty full", 32'(aempty4), 32'd0);
      check("t5 wready full", 32'(if4.wready), 32'd0);
      step();

      // Test 4: push+pop while full -> only the pop is taken.
      if4.wvalid = 1'b1;
      if4.wdata  = 16'hEEEE;
      if4.rready = 1'b1;
      mid();
      check("t4 wready blocked", 32'(if4.wready), 32'd0);
      step();
      if4.wvalid = 1'b0;
      if4.rready = 1'b0;
      mid();
      check("t4 depth 4->3", 32'(depth4), 32'd3);
      check("t4 wready reopened", 32'(if4.wready), 32'd1);

      // Test 6: flush at depth 2 with a pending write.
      step();
      if4.rready = 1'b1;
      mid();
      step();
      if4.rready = 1'b0;
      mid();
      check("t6 depth before clr", 32'(depth4), 32'd2);
      step();
      clr4       = 1'b1;
      if4.wvalid = 1'b1;
      if4.wdata  = 16'h1234;
      mid();
      check("t6 wready during clr", 32'(if4.wready), 32'd0);
      check("t6 rvalid during clr", 32'(if4.rvalid), 32'd0);
      step();
      clr4       = 1'b0;
      if4.wvalid = 1'b0;
      q4.delete();
      mid();
      check("t6 depth after clr", 32'(depth4), 32'd0);
      check("t6 rvalid after clr", 32'(if4.rvalid), 32'd0);
      check("t6 err after clr", 32'(err4), 32'd0);
      step();

      // Reset in the middle of a write burst.
      if3.wvalid = 1'b1;
      if3.wdata  = 16'h6001;
      q3.push_back(16'h6001);
      step();
      if3.wdata = 16'h6002;
      q3.push_back(16'h6002);
      step();
      if3.wdata = 16'h6003;
      rst_n     = 1'b0;
      mid();
      check("mid-reset wready gated", 32'(if3.wready), 32'd0);
      check("mid-reset rvalid gated", 32'(if3.rvalid), 32'd0);
      step();
      rst_n      = 1'b1;
      if3.wvalid = 1'b0;
      q3.delete();
      mid();
      check("mid-reset depth", 32'(depth3), 32'd0);
      check("mid-reset rvalid", 32'(if3.rvalid), 32'd0);
      check("mid-reset wptr", 32'(dut3.wptr), 32'd0);
      step();

      // FIFO usable again after reset.
      if3.wvalid = 1'b1;
      if3.wdata  = 16'h7777;
      q3.push_back(16'h7777);
      step();
      if3.wvalid = 1'b0;
      if3.rready = 1'b1;
      mid();
      step();
      if3.rready = 1'b0;
      mid();
      check("final d3 scoreboard drained", 32'(q3.size()), 32'd0);
      check("final d4 scoreboard drained", 32'(q4.size()), 32'd0);
      check("final d3 err", 32'(err3), 32'd0);
      check("final d4 err", 32'(err4), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
